// File: rtl/alloc_req_scheduler.sv
// alloc_req_scheduler: round-robin front end that shares one allocator core
// among NUM_REQ requesters. Each accepted request is validated, its size is
// rounded up to the requested power-of-two alignment, the aligned size is sent
// to the core, and the core's answer is routed back to the originating port.
// Only one request is in flight at any time.
module alloc_req_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 64,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_size_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_align_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic                        rsp_error_o,
  output logic [DATA_W-1:0]           rsp_addr_o,
  output logic                        core_req_valid_o,
  input  logic                        core_req_ready_i,
  output logic [DATA_W-1:0]           core_req_size_o,
  input  logic                        core_rsp_valid_i,
  input  logic [DATA_W-1:0]           core_rsp_addr_i,
  input  logic                        core_rsp_error_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // (base + off) mod NUM_REQ; works for non-power-of-two NUM_REQ as well.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return ID_W'(s);
  endfunction

  state_e            state_q,   state_d;
  logic [ID_W-1:0]   rr_q,      rr_d;
  logic [ID_W-1:0]   grant_q,   grant_d;
  logic [DATA_W-1:0] size_q,    size_d;
  logic [DATA_W-1:0] align_q,   align_d;
  logic [DATA_W-1:0] aligned_q, aligned_d;
  logic [DATA_W-1:0] addr_q,    addr_d;
  logic              err_q,     err_d;

  logic              found_s;
  logic [ID_W-1:0]   gnt_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] align_m1_s;
  logic              chk_err_s;
  logic [DATA_W-1:0] chk_aligned_s;

  // The sum is one bit wider than DATA_W so its top bit is the overflow carry.
  assign sum_s         = {1'b0, size_q} + {1'b0, align_q} - {{DATA_W{1'b0}}, 1'b1};
  assign align_m1_s    = align_q - {{(DATA_W-1){1'b0}}, 1'b1};
  assign chk_err_s     = (size_q == {DATA_W{1'b0}}) || (align_q == {DATA_W{1'b0}}) ||
                         ((align_q & align_m1_s) != {DATA_W{1'b0}}) || sum_s[DATA_W];
  assign chk_aligned_s = (sum_s[DATA_W-1:0]) & (~align_m1_s);

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  always_comb begin
    found_s = 1'b0;
    gnt_s   = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req_valid_i[wrap_idx(rr_q, i)]) begin
        found_s = 1'b1;
        gnt_s   = wrap_idx(rr_q, i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= {ID_W{1'b0}};
      grant_q   <= {ID_W{1'b0}};
      size_q    <= {DATA_W{1'b0}};
      align_q   <= {DATA_W{1'b0}};
      aligned_q <= {DATA_W{1'b0}};
      addr_q    <= {DATA_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      size_q    <= size_d;
      align_q   <= align_d;
      aligned_q <= aligned_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    size_d    = size_q;
    align_d   = align_q;
    aligned_d = aligned_q;
    addr_d    = addr_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d = gnt_s;
          size_d  = req_size_i[int'(gnt_s)*DATA_W +: DATA_W];
          align_d = req_align_i[int'(gnt_s)*DATA_W +: DATA_W];
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        addr_d = {DATA_W{1'b0}};
        if (chk_err_s) begin
          err_d     = 1'b1;
          aligned_d = {DATA_W{1'b0}};
          state_d   = ST_RESP;
        end else begin
          err_d     = 1'b0;
          aligned_d = chk_aligned_s;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_req_ready_i) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (core_rsp_valid_i) begin
          addr_d  = core_rsp_addr_i;
          err_d   = core_rsp_error_i;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        rr_d    = wrap_idx(grant_q, 1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state; only req_ready_o looks at inputs.
  always_comb begin
    req_ready_o      = {NUM_REQ{1'b0}};
    rsp_valid_o      = {NUM_REQ{1'b0}};
    rsp_error_o      = 1'b0;
    rsp_addr_o       = {DATA_W{1'b0}};
    core_req_valid_o = 1'b0;
    core_req_size_o  = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          req_ready_o[gnt_s] = 1'b1;
        end else begin
          req_ready_o = {NUM_REQ{1'b0}};
        end
      end
      ST_ISSUE: begin
        core_req_valid_o = 1'b1;
        core_req_size_o  = aligned_q;
      end
      ST_RESP: begin
        rsp_valid_o[grant_q] = 1'b1;
        rsp_error_o          = err_q;
        // A failed allocation never leaks whatever address the core drove.
        rsp_addr_o           = err_q ? {DATA_W{1'b0}} : addr_q;
      end
      default: begin
        core_req_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alloc_req_scheduler.sv
// Directed testbench for alloc_req_scheduler (NUM_REQ=4, DATA_W=64).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_alloc_req_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_size;
  logic [255:0] req_align;
  logic [3:0]   rsp_valid;
  logic         rsp_error;
  logic [63:0]  rsp_addr;
  logic         core_req_valid;
  logic         core_req_ready;
  logic [63:0]  core_req_size;
  logic         core_rsp_valid;
  logic [63:0]  core_rsp_addr;
  logic         core_rsp_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alloc_req_scheduler #(.NUM_REQ(4), .DATA_W(64)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_size_i       (req_size),
    .req_align_i      (req_align),
    .rsp_valid_o      (rsp_valid),
    .rsp_error_o      (rsp_error),
    .rsp_addr_o       (rsp_addr),
    .core_req_valid_o (core_req_valid),
    .core_req_ready_i (core_req_ready),
    .core_req_size_o  (core_req_size),
    .core_rsp_valid_i (core_rsp_valid),
    .core_rsp_addr_i  (core_rsp_addr),
    .core_rsp_error_i (core_rsp_error)
  );

  // One complete transaction from a single requester, checked cycle by cycle.
  task automatic do_txn(input string nm, input int port, input logic [63:0] size,
                        input logic [63:0] align, input logic exp_err, input logic [63:0] exp_al,
                        input int stall, input logic [63:0] caddr, input logic cerr);
    logic [3:0]  oh;
    logic [63:0] exp_addr;
    oh = 4'b0001 << port;
    exp_addr = cerr ? 64'd0 : caddr;
    @(negedge clk);
    req_valid = 4'b0000;
    req_valid[port] = 1'b1;
    req_size[port*64 +: 64]  = size;
    req_align[port*64 +: 64] = align;
    #1;
    tests++;
    if (req_ready !== oh) begin
      fails++; $display("FAIL %s accept: req_ready=%b expected %b", nm, req_ready, oh);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests++;
    if (core_req_valid !== 1'b0 || rsp_valid !== 4'b0000) begin
      fails++; $display("FAIL %s align_cycle: core_req_valid=%b rsp_valid=%b expected 0 0000", nm, core_req_valid, rsp_valid);
    end
    @(negedge clk);
    #1;
    if (exp_err) begin
      tests++;
      if (rsp_valid !== oh || rsp_error !== 1'b1 || rsp_addr !== 64'd0 || core_req_valid !== 1'b0) begin
        fails++; $display("FAIL %s err_rsp: rsp_valid=%b err=%b addr=%h core_req_valid=%b expected %b 1 0 0",
                          nm, rsp_valid, rsp_error, rsp_addr, core_req_valid, oh);
      end
      @(negedge clk);
      #1;
      tests++;
      if (rsp_valid !== 4'b0000 || rsp_error !== 1'b0 || core_req_valid !== 1'b0) begin
        fails++; $display("FAIL %s err_after: rsp_valid=%b err=%b core_req_valid=%b expected 0000 0 0", nm, rsp_valid, rsp_error, core_req_valid);
      end
    end else begin
      for (int i = 0; i < stall; i++) begin
        tests++;
        if (core_req_valid !== 1'b1 || core_req_size !== exp_al) begin
          fails++; $display("FAIL %s stall%0d: core_req_valid=%b size=%0d expected 1 %0d", nm, i, core_req_valid, core_req_size, exp_al);
        end
        @(negedge clk);
        #1;
      end
      tests++;
      if (core_req_valid !== 1'b1 || core_req_size !== exp_al || rsp_valid !== 4'b0000) begin
        fails++; $display("FAIL %s issue: core_req_valid=%b size=%0d rsp_valid=%b expected 1 %0d 0000", nm, core_req_valid, core_req_size, rsp_valid, exp_al);
      end
      core_req_ready = 1'b1;
      @(negedge clk);
      core_req_ready = 1'b0;
      #1;
      tests++;
      if (core_req_valid !== 1'b0 || core_req_size !== 64'd0) begin
        fails++; $display("FAIL %s wait: core_req_valid=%b size=%0d expected 0 0", nm, core_req_valid, core_req_size);
      end
      @(negedge clk);
      core_rsp_valid = 1'b1;
      core_rsp_addr  = caddr;
      core_rsp_error = cerr;
      @(negedge clk);
      core_rsp_valid = 1'b0;
      core_rsp_addr  = 64'd0;
      core_rsp_error = 1'b0;
      #1;
      tests++;
      if (rsp_valid !== oh || rsp_error !== cerr || rsp_addr !== exp_addr) begin
        fails++; $display("FAIL %s rsp: rsp_valid=%b err=%b addr=%h expected %b %b %h", nm, rsp_valid, rsp_error, rsp_addr, oh, cerr, exp_addr);
      end
      @(negedge clk);
      #1;
      tests++;
      if (rsp_valid !== 4'b0000 || rsp_addr !== 64'd0 || rsp_error !== 1'b0) begin
        fails++; $display("FAIL %s rsp_after: rsp_valid=%b err=%b addr=%h expected 0000 0 0", nm, rsp_valid, rsp_error, rsp_addr);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'b0000; req_size = '0; req_align = '0;
    core_req_ready = 1'b0; core_rsp_valid = 1'b0; core_rsp_addr = 64'd0; core_rsp_error = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_error !== 1'b0 || rsp_addr !== 64'd0 ||
        core_req_valid !== 1'b0 || core_req_size !== 64'd0) begin
      fails++; $display("FAIL reset_outputs: ready=%b rsp_valid=%b err=%b addr=%h core_valid=%b core_size=%h expected all 0",
                        req_ready, rsp_valid, rsp_error, rsp_addr, core_req_valid, core_req_size);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    @(negedge clk);
    req_valid = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      req_size[p*64 +: 64]  = 64'd1;
      req_align[p*64 +: 64] = 64'd1;
    end
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      #1;
      tests++;
      if (req_ready !== exp_oh) begin
        fails++; $display("FAIL rr_grant%0d: req_ready=%b expected %b", k, req_ready, exp_oh);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (core_req_valid !== 1'b1 || core_req_size !== 64'd1) begin
        fails++; $display("FAIL rr_issue%0d: core_req_valid=%b size=%0d expected 1 1", k, core_req_valid, core_req_size);
      end
      core_req_ready = 1'b1;
      @(negedge clk);
      core_req_ready = 1'b0;
      core_rsp_valid = 1'b1;
      core_rsp_addr  = 64'h100 + 64'(k);
      @(negedge clk);
      core_rsp_valid = 1'b0;
      #1;
      tests++;
      if (rsp_valid !== exp_oh || rsp_addr !== 64'h100 + 64'(k) || req_ready !== 4'b0000) begin
        fails++; $display("FAIL rr_rsp%0d: rsp_valid=%b addr=%h ready=%b expected %b %h 0000", k, rsp_valid, rsp_addr, req_ready, exp_oh, 64'h100 + 64'(k));
      end
      @(negedge clk);
      if (k == 4) begin
        req_valid = 4'b0000;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    do_txn("single_p1", 1, 64'd13, 64'd8, 1'b0, 64'd16, 0, 64'h1000, 1'b0);
  endtask

  task automatic test_align_checks;
    do_txn("size_zero",     2, 64'd0, 64'd8, 1'b1, 64'd0, 0, 64'd0, 1'b0);
    do_txn("align_npow2",   0, 64'd20, 64'd12, 1'b1, 64'd0, 0, 64'd0, 1'b0);
    do_txn("align_zero",    3, 64'd20, 64'd0, 1'b1, 64'd0, 0, 64'd0, 1'b0);
    do_txn("overflow",      1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd8, 1'b1, 64'd0, 0, 64'd0, 1'b0);
    do_txn("exact16",       0, 64'd16, 64'd16, 1'b0, 64'd16, 0, 64'h2000, 1'b0);
    do_txn("top_no_ovf",    2, 64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h3000, 1'b0);
  endtask

  task automatic test_stall_core_err;
    do_txn("stall_err", 3, 64'd5, 64'd4, 1'b0, 64'd8, 5, 64'hDEAD, 1'b1);
  endtask

  task automatic test_reset_in_wait;
    // Leave the round-robin pointer at 2 so a post-reset grant to port 0 is meaningful.
    do_txn("pre_reset", 1, 64'd3, 64'd2, 1'b0, 64'd4, 0, 64'h40, 1'b0);
    @(negedge clk);
    req_valid = 4'b0100;
    req_size[2*64 +: 64]  = 64'd8;
    req_align[2*64 +: 64] = 64'd8;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    core_req_ready = 1'b1;
    @(negedge clk);
    core_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_error !== 1'b0 || rsp_addr !== 64'd0 ||
        core_req_valid !== 1'b0 || core_req_size !== 64'd0) begin
      fails++; $display("FAIL rst_wait_outputs: ready=%b rsp_valid=%b err=%b addr=%h core_valid=%b expected all 0",
                        req_ready, rsp_valid, rsp_error, rsp_addr, core_req_valid);
    end
    core_rsp_valid = 1'b1;
    core_rsp_addr  = 64'hBEEF;
    @(negedge clk);
    core_rsp_valid = 1'b0;
    core_rsp_addr  = 64'd0;
    #1;
    tests++;
    if (rsp_valid !== 4'b0000 || rsp_addr !== 64'd0 || core_req_valid !== 1'b0) begin
      fails++; $display("FAIL rst_stale_rsp: rsp_valid=%b addr=%h core_valid=%b expected 0000 0 0", rsp_valid, rsp_addr, core_req_valid);
    end
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL rst_next_grant: req_ready=%b expected 0001", req_ready);
    end
    // Withdraw before the clock edge: no grant must be taken.
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (req_ready !== 4'b0000 || core_req_valid !== 1'b0 || rsp_valid !== 4'b0000) begin
      fails++; $display("FAIL drop_valid: ready=%b core_valid=%b rsp_valid=%b expected 0000 0 0000", req_ready, core_req_valid, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_align_checks();
    test_stall_core_err();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alloc_req_scheduler.md
Name: alloc_req_scheduler

Overview:
- Shares the single allocator core among NUM_REQ requesters using round-robin arbitration.
- Per accepted request it validates and aligns size to alignment, issues the aligned size to the core, waits for the core response, and routes result back to the originating requester.
- One request in flight at a time; sits between requester ports and allocator core.

Parameters:
NUM_REQ, 4, number of requester ports (>=2)
DATA_W, 64, size/alignment/address width (matches falafel_pkg::DATA_W)
ID_W, $clog2(NUM_REQ), grant index width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
req_size_i  in  NUM_REQ*DATA_W  requested sizes, requester k at [k*DATA_W +: DATA_W]
req_align_i  in  NUM_REQ*DATA_W  requested alignments, same packing
rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the granted requester
rsp_error_o  out  1  error flag, valid only with rsp_valid_o
rsp_addr_o  out  DATA_W  allocated address, valid only with rsp_valid_o
core_req_valid_o  out  1  request to allocator core
core_req_ready_i  in  1  core accepts request
core_req_size_o  out  DATA_W  aligned size to core
core_rsp_valid_i  in  1  core response valid (single-cycle)
core_rsp_addr_i  in  DATA_W  core address
core_rsp_error_i  in  1  core failure (e.g. no free block)

Behaviour:
- Reset (rst_i high at posedge): state IDLE, rr pointer=0, latched size/align/grant=0; all outputs 0 from the next cycle. Reset mid-transaction aborts silently: no rsp pulse, core_req_valid_o drops.
- FSM states: IDLE, ALIGN, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i bit is set, grant the first set bit searching from rr pointer upward, wrapping mod NUM_REQ.
  - Same cycle: req_ready_o[g]=1 combinationally; latch size, alignment, g; go to ALIGN.
  - If no request, req_ready_o=0 and stay in IDLE.
- ALIGN, one cycle, registered result. Error if any of:
  - size==0
  - align==0
  - align not a power of two, i.e. (align & (align-1))!=0
  - size+align-1 overflows DATA_W, i.e. carry out of a DATA_W+1-bit sum
- ALIGN outcome:
  - Otherwise aligned = (size + align - 1) & ~(align - 1), with explicit parenthesisation; go to ISSUE.
  - On error, go to RESP with error=1, addr=0; the core is never contacted.
- ISSUE:
  - core_req_valid_o=1 and core_req_size_o=aligned, held stable until core_req_ready_i.
  - On ready, go to WAIT.
  - core_req_size_o=0 whenever core_req_valid_o=0.
- WAIT:
  - On core_rsp_valid_i, latch addr and error, go to RESP.
  - core_rsp_valid_i in any other state is ignored.
  - The same-cycle ready/response case cannot occur: response is accepted only in WAIT.
- RESP:
  - rsp_valid_o[g]=1 for exactly one cycle, with rsp_addr_o/rsp_error_o.
  - rr pointer <= (g+1) mod NUM_REQ; go to IDLE.
  - If the core reported an error, rsp_addr_o is forced to 0.
  - rsp_addr_o/rsp_error_o are 0 when no pulse.
- Latency:
  - Accept at cycle T.
  - Error response at T+2.
  - Core request first visible at T+2.
  - Response one cycle after core_rsp_valid_i.
  - Next accept earliest the cycle after RESP.
- Requester keeps req_valid_i until req_ready_o; dropping valid before grant is legal (no grant).

Test Plan:
- Single req port 1: size=13, align=8, core ready immediate, core addr=0x1000 two cycles later -> core_req_size_o=16 at T+2; rsp_valid_o=4'b0010, addr=0x1000, error=0.
- size=0, align=8 -> rsp at T+2 with error=1, addr=0; core_req_valid_o never asserted.
- Non-power-of-two and overflow cases:
  - align=12 -> error.
  - align=0 -> error.
  - size=2^64-3, align=8 -> overflow error.
  - size=16, align=16 -> aligned 16, no error.
- All four requesting continuously, each size=1, align=1 -> grants in order 0,1,2,3,0; no port granted twice before others.
- core_req_ready_i held low 5 cycles -> core_req_valid_o and size stay stable; core_rsp_error_i=1 with addr=0xDEAD -> rsp error=1, addr=0.
- Assert rst_i while in WAIT -> no rsp pulse; state IDLE, all outputs 0; pending core_rsp_valid_i after reset ignored; next grant starts at port 0.
